// File: rtl/wimax_deinterleaver.sv
// QPSK (Ncbps=192, d=16) receive bit deinterleaver, ping-pong banks, 1 bit/cycle.
// Optional last_out marker on data_out_index==191 when DEINT_LAST_EN is defined.
module wimax_deinterleaver #(
  parameter int NCBPS = 192,
  parameter int NCPC  = 2,
  parameter int D     = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       valid_out,
  input  logic       ready_in,
`ifdef DEINT_LAST_EN
  output logic       last_out,
`endif
  output logic [7:0] data_out_index
);

  localparam int R = NCBPS / D;

  localparam logic [3:0] R_LAST = 4'(R - 1);
  localparam logic [3:0] Q_LAST = 4'(D - 1);
  localparam logic [7:0] K_LAST = 8'(NCBPS - 1);

  if (NCPC != 2) begin : g_ncpc_err
    $error("wimax_deinterleaver: only NCPC=2 is supported");
  end
  if ((NCBPS % D) != 0) begin : g_div_err
    $error("wimax_deinterleaver: NCBPS must be a multiple of D");
  end
  if (NCBPS > 256 || R > 16 || D > 16) begin : g_size_err
    $error("wimax_deinterleaver: counters are 4/4/8 bits wide");
  end

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_t;

  bank_t            st_q [2];
  bank_t            st_d [2];
  logic [NCBPS-1:0] mem_q [2];
  logic [NCBPS-1:0] mem_d [2];

  logic       wbank_q, wbank_d;
  logic       rbank_q, rbank_d;
  logic [3:0] r_q, r_d;
  logic [3:0] q_q, q_d;
  logic [7:0] rptr_q, rptr_d;
  logic       ready_q, ready_d;
  logic       valid_q, valid_d;
  logic       dout_q, dout_d;
  logic       last_q, last_d;

  logic       wr_en;
  logic       rd_en;
  logic [7:0] waddr;

  assign wr_en = valid_in & ready_q;
  assign rd_en = valid_q & ready_in;

  // Received j = R*q + r lands at original index k = D*r + q.
  assign waddr = 8'(D * int'(r_q) + int'(q_q));

  always_comb begin
    st_d    = st_q;
    mem_d   = mem_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    r_d     = r_q;
    q_d     = q_q;
    rptr_d  = rptr_q;

    if (rd_en) begin
      st_d[rbank_q] = DRAINING;
      if (rptr_q == K_LAST) begin
        st_d[rbank_q] = EMPTY;
        rbank_d       = ~rbank_q;
        rptr_d        = 8'd0;
      end else begin
        rptr_d = rptr_q + 8'd1;
      end
    end

    if (wr_en) begin
      mem_d[wbank_q][waddr] = data_in;
      st_d[wbank_q]         = FILLING;
      if (r_q == R_LAST) begin
        r_d = 4'd0;
        q_d = q_q + 4'd1;
        if (q_q == Q_LAST) begin
          q_d           = 4'd0;
          st_d[wbank_q] = FULL;
          wbank_d       = ~wbank_q;
        end
      end else begin
        r_d = r_q + 4'd1;
      end
    end

    ready_d = (st_d[wbank_d] == EMPTY) ||
              (st_d[wbank_d] == FILLING);
    valid_d = (st_d[rbank_d] == FULL) ||
              (st_d[rbank_d] == DRAINING);
    // Read from next-state storage so a same-edge write is forwarded.
    dout_d  = valid_d & mem_d[rbank_d][rptr_d];
    last_d  = valid_d && (rptr_d == K_LAST);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      r_q     <= 4'd0;
      q_q     <= 4'd0;
      rptr_q  <= 8'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      dout_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      r_q     <= r_d;
      q_q     <= q_d;
      rptr_q  <= rptr_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ready_out      = ready_q;
  assign valid_out      = valid_q;
  assign data_out       = dout_q;
  assign data_out_index = rptr_q;

`ifdef DEINT_LAST_EN
  assign last_out = last_q;
`else
  logic unused_last;
  assign unused_last = last_q;
`endif

endmodule

// File: tb/tb_wimax_deinterleaver.sv
// Self-checking bench for wimax_deinterleaver: ordering table, round trip,
// streaming, backpressure, mid-block reset and stalled single block.
module tb_wimax_deinterleaver;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       data_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       data_out;
  logic       valid_out;
  logic       ready_in = 1'b0;
  logic [7:0] data_out_index;
`ifdef DEINT_LAST_EN
  logic       last_out;
`endif

  always #5 clk = ~clk;

  wimax_deinterleaver dut (
    .clk            (clk),
    .resetN         (resetN),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
`ifdef DEINT_LAST_EN
    .last_out       (last_out),
`endif
    .data_out_index (data_out_index)
  );

  typedef struct {
    int hot_j;
    int exp_k;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  bit         tx_q[$];
  bit         exp_q[$];
  bit         out_q[$];
  logic [7:0] idx_q[$];
  int sent, first_valid, last_acc, last_recv, rdy_drop;
  int last_err, last_cnt;

  function automatic void check(string nm, int act, int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endfunction

  function automatic logic [191:0] ilv(input logic [191:0] s);
    logic [191:0] t;
    t = '0;
    for (int k = 0; k < 192; k++) t[12*(k%16) + k/16] = s[k];
    return t;
  endfunction

  function automatic logic [191:0] rnd_block();
    logic [191:0] s;
    for (int i = 0; i < 192; i++) s[i] = 1'($urandom_range(1));
    return s;
  endfunction

  task automatic clear_run();
    tx_q.delete(); exp_q.delete(); out_q.delete(); idx_q.delete();
    sent = 0; first_valid = -1; last_acc = -1; last_recv = -1;
    rdy_drop = 0; last_err = 0; last_cnt = 0;
  endtask

  task automatic add_block(input logic [191:0] t, input logic [191:0] e);
    for (int j = 0; j < 192; j++) tx_q.push_back(t[j]);
    for (int k = 0; k < 192; k++) exp_q.push_back(e[k]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic run(input string nm, input int in_stall,
                     input int out_stall, input int max_cyc);
    int c;
    c = 0;
    while (out_q.size() < exp_q.size() && c < max_cyc) begin
      @(negedge clk);
      if (valid_out && first_valid < 0) first_valid = c;
      if (sent < tx_q.size() && !ready_out) rdy_drop++;
      ready_in = int'($urandom_range(99)) >= out_stall;
      valid_in = (sent < tx_q.size()) && (int'($urandom_range(99)) >= in_stall);
      data_in  = valid_in ? tx_q[sent] : 1'b0;
`ifdef DEINT_LAST_EN
      if (last_out !== (valid_out && data_out_index == 8'd191)) last_err++;
      if (last_out && valid_out && ready_in) last_cnt++;
`endif
      if (valid_in && ready_out) begin
        sent++;
        last_acc = c;
      end
      if (valid_out && ready_in) begin
        out_q.push_back(data_out);
        idx_q.push_back(data_out_index);
        last_recv = c;
      end
      c++;
    end
    check({nm, "_count"}, out_q.size(), exp_q.size());
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b0;
  endtask

  task automatic check_out(input string nm);
    int bad, ibad;
    bad = 0; ibad = 0;
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      if (out_q[i] != exp_q[i]) bad++;
      if (int'(idx_q[i]) != i % 192) ibad++;
    end
    check({nm, "_bits"}, bad, 0);
    check({nm, "_idx"}, ibad, 0);
  endtask

  vec_t vecs[7];
  logic [191:0] t, e, rt_src;

  initial begin
    vecs[0] = '{hot_j: 12,  exp_k: 1};
    vecs[1] = '{hot_j: 1,   exp_k: 16};
    vecs[2] = '{hot_j: 191, exp_k: 191};
    vecs[3] = '{hot_j: 0,   exp_k: 0};
    vecs[4] = '{hot_j: 13,  exp_k: 17};
    vecs[5] = '{hot_j: 24,  exp_k: 2};
    vecs[6] = '{hot_j: 100, exp_k: 72};

    do_reset();
    check("rst_valid", int'(valid_out), 0);
    check("rst_ready", int'(ready_out), 1);
    check("rst_data",  int'(data_out), 0);
    check("rst_index", int'(data_out_index), 0);

    foreach (vecs[v]) begin
      int ones, pos;
      do_reset();
      clear_run();
      t = '0; t[vecs[v].hot_j] = 1'b1;
      e = '0; e[vecs[v].exp_k] = 1'b1;
      add_block(t, e);
      run($sformatf("ord%0d", v), 0, 0, 600);
      check($sformatf("ord%0d_latency", v), first_valid, last_acc + 1);
      ones = 0; pos = -1;
      foreach (out_q[i]) if (out_q[i]) begin ones++; pos = int'(idx_q[i]); end
      check($sformatf("ord%0d_ones", v), ones, 1);
      check($sformatf("ord%0d_hot", v), pos, vecs[v].exp_k);
      check_out($sformatf("ord%0d", v));
    end

    do_reset();
    clear_run();
    rt_src = rnd_block();
    add_block(ilv(rt_src), rt_src);
    run("rt", 0, 0, 600);
    check_out("rt");

    do_reset();
    clear_run();
    for (int b = 0; b < 4; b++) begin
      e = rnd_block();
      add_block(ilv(e), e);
    end
    run("strm", 0, 0, 2000);
    check("strm_ready_drop", rdy_drop, 0);
    check("strm_first_valid", first_valid, 192);
    check("strm_span", last_recv - first_valid + 1, 768);
    check_out("strm");

    do_reset();
    clear_run();
    for (int b = 0; b < 3; b++) begin
      e = rnd_block();
      add_block(ilv(e), e);
    end
    begin
      int ibad;
      ibad = 0;
      for (int c = 0; c < 390; c++) begin
        @(negedge clk);
        if (data_out_index != 8'd0) ibad++;
        ready_in = 1'b0;
        valid_in = 1'b1;
        data_in  = tx_q[sent];
        if (ready_out) sent++;
      end
      @(negedge clk);
      check("bp_accepted", sent, 384);
      check("bp_ready", int'(ready_out), 0);
      check("bp_valid", int'(valid_out), 1);
      check("bp_index_hold", ibad + int'(data_out_index), 0);
    end
    run("bp", 0, 0, 3000);
    check_out("bp");

    do_reset();
    clear_run();
    for (int b = 0; b < 2; b++) begin
      e = rnd_block();
      add_block(ilv(e), e);
    end
    for (int c = 0; c < 292; c++) begin
      @(negedge clk);
      ready_in = 1'b1;
      valid_in = 1'b1;
      data_in  = tx_q[sent];
      if (ready_out) sent++;
    end
    @(negedge clk);
    check("mrst_sent", sent, 292);
    check("mrst_pre_valid", int'(valid_out), 1);
    resetN = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    @(negedge clk);
    check("mrst_valid", int'(valid_out), 0);
    check("mrst_ready", int'(ready_out), 1);
    check("mrst_index", int'(data_out_index), 0);
    resetN = 1'b1;
    clear_run();
    e = rnd_block();
    add_block(ilv(e), e);
    run("mrst", 0, 0, 600);
    check_out("mrst");

    do_reset();
    clear_run();
    add_block(ilv(rt_src), rt_src);
    run("stall", 30, 30, 3000);
    check_out("stall");
`ifdef DEINT_LAST_EN
    check("last_mismatch", last_err, 0);
    check("last_count", last_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
